// File: rtl/audio_pkg.sv
// Shared types and constants for the I2S audio ADC receiver.
package audio_pkg;

   localparam int SAMPLE_W    = 16;
   localparam int SYNC_STAGES = 2;

   typedef enum logic [1:0] {
      IDLE,
      SKIP,
      SHIFT,
      HOLD
   } rx_state_t;

endpackage

// File: rtl/i2s_edge_sync.sv
// Brings the codec BCLK/LRCK/DAT pins into the Clk domain and produces a
// one-cycle bit strobe on each BCLK rising edge, with LRCK/DAT aligned to it.
module i2s_edge_sync
   import audio_pkg::*;
(
   input  logic Clk,
   input  logic Reset,
   input  logic bclk,
   input  logic lrck,
   input  logic dat,
   output logic bit_stb,
   output logic lrck_bit,
   output logic dat_bit
);

   logic [SYNC_STAGES-1:0] bclk_sync;
   logic [SYNC_STAGES-1:0] lrck_sync;
   logic [SYNC_STAGES-1:0] dat_sync;
   logic                   bclk_prev;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         bclk_sync <= '0;
         lrck_sync <= '0;
         dat_sync  <= '0;
         bclk_prev <= 1'b0;
         bit_stb   <= 1'b0;
         lrck_bit  <= 1'b0;
         dat_bit   <= 1'b0;
      end else begin
         bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], bclk};
         lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], lrck};
         dat_sync  <= {dat_sync[SYNC_STAGES-2:0], dat};
         // strobe stage: LRCK/DAT registered alongside so all three line up
         bclk_prev <= bclk_sync[SYNC_STAGES-1];
         bit_stb   <= bclk_sync[SYNC_STAGES-1] & ~bclk_prev;
         lrck_bit  <= lrck_sync[SYNC_STAGES-1];
         dat_bit   <= dat_sync[SYNC_STAGES-1];
      end
   end

endmodule

// File: rtl/audio_adc_receiver.sv
// I2S ADC receiver: deserialises left/right 16-bit words and presents them as
// a valid/ready pair. Define AUDIO_RX_MONO_MIX_EN to output (L+R)>>>1 on both.
module audio_adc_receiver
   import audio_pkg::*;
(
   input  logic                Clk,
   input  logic                Reset,
   input  logic                enable,
   input  logic                AUD_BCLK,
   input  logic                AUD_ADCLRCK,
   input  logic                AUD_ADCDAT,
   output logic [SAMPLE_W-1:0] sample_left,
   output logic [SAMPLE_W-1:0] sample_right,
   output logic                sample_valid,
   input  logic                sample_ready,
   output logic                overrun,
   output logic                frame_err
);

   rx_state_t           state, state_nxt;
   logic                bit_stb, lrck_bit, dat_bit;
   logic                lrck_prev, chan, left_ok;
   logic [3:0]          bit_cnt;
   logic [SAMPLE_W-1:0] shreg, hold_l, word;
   logic [SAMPLE_W-1:0] out_l, out_r;
   logic                lrck_edge, start_ch, shift_en, word_done, trunc;
   logic                pair, handshake;

   i2s_edge_sync u_sync (
      .Clk      (Clk),
      .Reset    (Reset),
      .bclk     (AUD_BCLK),
      .lrck     (AUD_ADCLRCK),
      .dat      (AUD_ADCDAT),
      .bit_stb  (bit_stb),
      .lrck_bit (lrck_bit),
      .dat_bit  (dat_bit)
   );

   assign lrck_edge = bit_stb && (lrck_bit != lrck_prev);
   assign word      = {shreg[SAMPLE_W-2:0], dat_bit};
   assign pair      = word_done && chan && left_ok;
   assign handshake = sample_valid && sample_ready;

`ifdef AUDIO_RX_MONO_MIX_EN
   function automatic logic [SAMPLE_W-1:0] mono_mix(input logic signed [SAMPLE_W-1:0] a,
                                                    input logic signed [SAMPLE_W-1:0] b);
      logic signed [SAMPLE_W:0] sum;
      sum = $signed({a[SAMPLE_W-1], a}) + $signed({b[SAMPLE_W-1], b});
      return SAMPLE_W'(sum >>> 1);
   endfunction

   assign out_l = mono_mix(hold_l, word);
   assign out_r = out_l;
`else
   assign out_l = hold_l;
   assign out_r = word;
`endif

   always_ff @(posedge Clk) begin
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start_ch  = 1'b0;
      shift_en  = 1'b0;
      word_done = 1'b0;
      trunc     = 1'b0;
      if (bit_stb) begin
         if (!enable) begin
            state_nxt = IDLE;
         end else begin
            case (state)
               IDLE: if (lrck_edge) begin
                  start_ch  = 1'b1;
                  state_nxt = SKIP;
               end
               // an edge here restarts the delay slot for the new channel
               SKIP: if (lrck_edge) start_ch = 1'b1;
                     else           state_nxt = SHIFT;
               SHIFT: if (lrck_edge) begin
                  trunc     = 1'b1;
                  start_ch  = 1'b1;
                  state_nxt = SKIP;
               end else begin
                  shift_en = 1'b1;
                  if (bit_cnt == 4'd15) begin
                     word_done = 1'b1;
                     state_nxt = HOLD;
                  end
               end
               HOLD: if (lrck_edge) begin
                  start_ch  = 1'b1;
                  state_nxt = SKIP;
               end
               default: state_nxt = IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         lrck_prev    <= 1'b0;
         chan         <= 1'b0;
         left_ok      <= 1'b0;
         bit_cnt      <= '0;
         shreg        <= '0;
         hold_l       <= '0;
         sample_left  <= '0;
         sample_right <= '0;
         sample_valid <= 1'b0;
         overrun      <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         if (bit_stb) lrck_prev <= lrck_bit;
         if (start_ch) begin
            chan    <= lrck_bit;
            bit_cnt <= '0;
            if (!lrck_bit) left_ok <= 1'b0;
         end
         if (shift_en) begin
            shreg   <= word;
            bit_cnt <= bit_cnt + 4'd1;
         end
         // a right word always consumes the stored left, paired or not
         if (word_done) begin
            if (!chan) begin
               hold_l  <= word;
               left_ok <= 1'b1;
            end else begin
               left_ok <= 1'b0;
            end
         end
         if (bit_stb && !enable) left_ok <= 1'b0;
         if (trunc) frame_err <= 1'b1;
         if (pair) begin
            if (!sample_valid || sample_ready) begin
               sample_left  <= out_l;
               sample_right <= out_r;
               sample_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (handshake) begin
            sample_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_audio_adc_receiver.sv
// Self-checking bench for audio_adc_receiver: randomized I2S frames against a
// segment-based behavioural model, plus fixed-value scenario checks.
module tb_audio_adc_receiver;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        enable = 1'b1;
   logic        AUD_BCLK = 1'b0;
   logic        AUD_ADCLRCK = 1'b0;
   logic        AUD_ADCDAT = 1'b0;
   logic        sample_ready = 1'b0;
   logic [15:0] sample_left, sample_right;
   logic        sample_valid, overrun, frame_err;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int rdy_mode = 0;
   int last_rise = 0;
   int vrise_cyc = -1;
   int valid_hi_cnt = 0;
   logic rst_e, rdy_e, en_e;

   typedef struct {
      int   due;
      logic l;
      logic d;
   } bit_ev_t;
   bit_ev_t evq[$];

   // behavioural model state
   bit          armed = 1'b0;
   logic        m_prev, m_active, m_left_ok, m_seg_ch;
   logic        m_bits[$];
   logic [15:0] m_hold_l, m_left, m_right, m_pair_r;
   logic        m_valid, m_over, m_ferr, m_pair;
   logic        prev_vld = 1'b0;

   audio_adc_receiver dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .enable       (enable),
      .AUD_BCLK     (AUD_BCLK),
      .AUD_ADCLRCK  (AUD_ADCLRCK),
      .AUD_ADCDAT   (AUD_ADCDAT),
      .sample_left  (sample_left),
      .sample_right (sample_right),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .overrun      (overrun),
      .frame_err    (frame_err)
   );

   always #10 Clk = ~Clk;

   always @(posedge Clk) begin
      cyc   <= cyc + 1;
      rst_e <= Reset;
      rdy_e <= sample_ready;
      en_e  <= enable;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [15:0] mix(input logic [15:0] l, input logic [15:0] r);
      int li, ri, s;
      li = $signed(l);
      ri = $signed(r);
      s  = (li + ri) >>> 1;
      return s[15:0];
   endfunction

   function automatic logic [15:0] exp_l(input logic [15:0] l, input logic [15:0] r);
`ifdef AUDIO_RX_MONO_MIX_EN
      return mix(l, r);
`else
      return (r == r) ? l : l;
`endif
   endfunction

   function automatic logic [15:0] exp_r(input logic [15:0] l, input logic [15:0] r);
`ifdef AUDIO_RX_MONO_MIX_EN
      return mix(l, r);
`else
      return (l == l) ? r : r;
`endif
   endfunction

   task automatic chk_pair(input string nm, input logic [15:0] raw_l, input logic [15:0] raw_r,
                           input logic [15:0] mono_v);
`ifdef AUDIO_RX_MONO_MIX_EN
      chk({nm, "_left"}, sample_left, mono_v);
      chk({nm, "_right"}, sample_right, mono_v);
`else
      chk({nm, "_left"}, sample_left, raw_l);
      chk({nm, "_right"}, sample_right, raw_r);
`endif
   endtask

   // One strobe of the serial stream: a channel runs from the strobe where LRCK
   // changes; the second strobe is the delay slot; the next 16 are the word.
   task automatic model_bit(input logic l, input logic d);
      logic [15:0] w;
      if (!en_e) begin
         m_active  = 1'b0;
         m_left_ok = 1'b0;
      end else if (l != m_prev) begin
         if (m_active && m_bits.size() >= 2 && m_bits.size() < 18) m_ferr = 1'b1;
         m_active = 1'b1;
         m_seg_ch = l;
         m_bits.delete();
         m_bits.push_back(d);
         if (!l) m_left_ok = 1'b0;
      end else if (m_active && m_bits.size() < 18) begin
         m_bits.push_back(d);
         if (m_bits.size() == 18) begin
            w = '0;
            for (int i = 2; i < 18; i++) w = {w[14:0], m_bits[i]};
            if (!m_seg_ch) begin
               m_hold_l  = w;
               m_left_ok = 1'b1;
            end else begin
               if (m_left_ok) begin
                  m_pair   = 1'b1;
                  m_pair_r = w;
               end
               m_left_ok = 1'b0;
            end
         end
      end
      m_prev = l;
   endtask

   // model update, per-cycle compare and ready generation
   initial begin
      bit_ev_t ev;
      forever begin
         @(negedge Clk);
         if (rst_e === 1'b1) begin
            armed = 1'b1;
            m_prev = 1'b0; m_active = 1'b0; m_left_ok = 1'b0; m_seg_ch = 1'b0;
            m_bits.delete();
            m_hold_l = '0; m_left = '0; m_right = '0; m_pair_r = '0;
            m_valid = 1'b0; m_over = 1'b0; m_ferr = 1'b0;
            evq.delete();
         end else if (armed) begin
            m_pair = 1'b0;
            while (evq.size() > 0 && evq[0].due <= cyc) begin
               ev = evq.pop_front();
               model_bit(ev.l, ev.d);
            end
            if (m_pair) begin
               if (!m_valid || rdy_e) begin
                  m_left  = exp_l(m_hold_l, m_pair_r);
                  m_right = exp_r(m_hold_l, m_pair_r);
                  m_valid = 1'b1;
               end else begin
                  m_over = 1'b1;
               end
            end else if (m_valid && rdy_e) begin
               m_valid = 1'b0;
            end
         end
         if (armed) begin
            chk("valid", sample_valid, m_valid);
            chk("left", sample_left, m_left);
            chk("right", sample_right, m_right);
            chk("overrun", overrun, m_over);
            chk("frame_err", frame_err, m_ferr);
         end
         if (sample_valid === 1'b1) valid_hi_cnt++;
         if (sample_valid === 1'b1 && prev_vld !== 1'b1) vrise_cyc = cyc;
         prev_vld = sample_valid;
         case (rdy_mode)
            1:       sample_ready = 1'b1;
            2:       sample_ready = 1'b0;
            default: sample_ready = 1'($urandom);
         endcase
      end
   end

   task automatic bit_slot(input logic l, input logic d);
      int      h;
      bit_ev_t e;
      h = $urandom_range(3, 6);
      @(negedge Clk);
      AUD_ADCLRCK = l;
      AUD_ADCDAT  = d;
      repeat (h) @(negedge Clk);
      AUD_BCLK = 1'b1;
      e.due = cyc + 4;
      e.l   = l;
      e.d   = d;
      evq.push_back(e);
      last_rise = cyc;
      repeat (h) @(negedge Clk);
      AUD_BCLK = 1'b0;
   endtask

   task automatic send_chan(input logic ch, input logic [23:0] data, input int nbits, input int pad);
      repeat (2) bit_slot(ch, 1'($urandom));
      for (int i = 0; i < nbits; i++) bit_slot(ch, data[23-i]);
      repeat (pad) bit_slot(ch, 1'($urandom));
   endtask

   task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int pad_l, input int pad_r);
      send_chan(1'b0, {l, 8'h00}, 16, pad_l);
      send_chan(1'b1, {r, 8'h00}, 16, pad_r);
   endtask

   task automatic do_reset(input bit check);
      repeat (6) @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      if (check) begin
         chk("rst_left", sample_left, 16'h0);
         chk("rst_right", sample_right, 16'h0);
         chk("rst_valid", sample_valid, 1'b0);
         chk("rst_overrun", overrun, 1'b0);
         chk("rst_frame_err", frame_err, 1'b0);
      end
      Reset = 1'b0;
   endtask

   initial begin
      logic [15:0] rl, rr;
      int          nb;
      repeat (5) @(negedge Clk);
      chk("init_left", sample_left, 16'h0);
      chk("init_right", sample_right, 16'h0);
      chk("init_valid", sample_valid, 1'b0);
      chk("init_overrun", overrun, 1'b0);
      chk("init_frame_err", frame_err, 1'b0);
      Reset = 1'b0;

      // basic pair and pin-to-valid latency
      rdy_mode = 1;
      send_chan(1'b1, 24'h3C3C00, 16, 0);
      valid_hi_cnt = 0;
      vrise_cyc = -1;
      send_frame(16'hA5C3, 16'h5A3C, 2, 0);
      repeat (12) @(negedge Clk);
      chk_pair("basic", 16'hA5C3, 16'h5A3C, 16'hFFFF);
      chk("latency", vrise_cyc - last_rise, 4);
      chk("valid_one_cycle", valid_hi_cnt, 1);
      chk("basic_overrun", overrun, 1'b0);

      // two frames with no consumer: first pair held, overrun set
      rdy_mode = 2;
      repeat (3) @(negedge Clk);
      send_frame(16'h1234, 16'hFEDC, 1, 0);
      send_frame(16'($urandom), 16'($urandom), 0, 0);
      repeat (12) @(negedge Clk);
      chk("ovr_valid", sample_valid, 1'b1);
      chk("ovr_flag", overrun, 1'b1);
      chk_pair("ovr_hold", 16'h1234, 16'hFEDC, 16'h0888);
      rdy_mode = 1;
      repeat (5) @(negedge Clk);
      chk("ovr_drained", sample_valid, 1'b0);
      chk("ovr_sticky", overrun, 1'b1);

      // truncated left word
      do_reset(1'b0);
      rdy_mode = 0;
      send_chan(1'b1, 24'h777700, 16, 0);
      valid_hi_cnt = 0;
      send_chan(1'b0, 24'hFFFF00, 10, 0);
      send_chan(1'b1, 24'h246800, 16, 1);
      repeat (12) @(negedge Clk);
      chk("trunc_frame_err", frame_err, 1'b1);
      chk("trunc_no_pair", valid_hi_cnt, 0);
      rdy_mode = 1;
      send_frame(16'h0F0F, 16'hF0F0, 1, 0);
      repeat (12) @(negedge Clk);
      chk_pair("after_trunc", 16'h0F0F, 16'hF0F0, 16'hFFFF);

      // reset mid-word with a pending pair
      rdy_mode = 2;
      send_frame(16'h1111, 16'h2222, 0, 0);
      send_chan(1'b0, 24'h555500, 6, 0);
      do_reset(1'b1);
      rdy_mode = 1;
      send_chan(1'b1, 24'h999900, 16, 0);
      valid_hi_cnt = 0;
      send_frame(16'h7FFF, 16'h8000, 0, 0);
      repeat (12) @(negedge Clk);
      chk_pair("post_reset", 16'h7FFF, 16'h8000, 16'hFFFF);
      chk("post_reset_one_pair", valid_hi_cnt, 1);

      // mixing boundaries
      send_frame(16'h7FFF, 16'h0001, 1, 0);
      repeat (12) @(negedge Clk);
      chk_pair("mix_pos", 16'h7FFF, 16'h0001, 16'h4000);
      send_frame(16'h8000, 16'h8000, 0, 0);
      repeat (12) @(negedge Clk);
      chk_pair("mix_neg", 16'h8000, 16'h8000, 16'h8000);

      // 24-bit codec words
      send_chan(1'b0, 24'h9ABCDE, 24, 0);
      send_chan(1'b1, 24'h123456, 24, 2);
      repeat (12) @(negedge Clk);
      chk_pair("w24", 16'h9ABC, 16'h1234, 16'hD678);

      // enable dropped mid-word keeps the pending pair
      rdy_mode = 2;
      send_frame(16'h4321, 16'h0123, 0, 0);
      send_chan(1'b0, 24'hABCD00, 6, 0);
      enable = 1'b0;
      for (int i = 0; i < 10; i++) bit_slot(1'b0, 1'($urandom));
      send_chan(1'b1, 24'hC0DE00, 16, 0);
      enable = 1'b1;
      repeat (8) @(negedge Clk);
      chk("en_valid_kept", sample_valid, 1'b1);
      chk("en_no_frame_err", frame_err, 1'b0);
      chk_pair("en_hold", 16'h4321, 16'h0123, 16'h2222);

      // randomized traffic
      rdy_mode = 0;
      for (int f = 0; f < 16; f++) begin
         rl = 16'($urandom);
         rr = 16'($urandom);
         nb = ($urandom_range(0, 3) == 0) ? 24 : 16;
         if ($urandom_range(0, 7) == 0)
            send_chan(1'b0, {rl, 8'($urandom)}, $urandom_range(1, 15), 0);
         else
            send_chan(1'b0, {rl, 8'($urandom)}, nb, $urandom_range(0, 5));
         send_chan(1'b1, {rr, 8'($urandom)}, nb, $urandom_range(0, 5));
      end
      repeat (20) @(negedge Clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #4000000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/audio_adc_receiver.md
AUDIO_ADC_RECEIVER -- requirements
Module: audio_adc_receiver

Interface
REQ-001 SHALL have port Clk, input, 1 bit: 50 MHz system clock, the only clock in the block.
REQ-002 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port enable, input, 1 bit: capture permitted while high.
REQ-004 SHALL have port AUD_BCLK, input, 1 bit: codec bit clock, asynchronous to Clk.
REQ-005 SHALL have port AUD_ADCLRCK, input, 1 bit: codec word select; low = left, high = right.
REQ-006 SHALL have port AUD_ADCDAT, input, 1 bit: codec serial ADC data, MSB first.
REQ-007 SHALL have port sample_left, output, 16 bits: last accepted left sample, two's complement.
REQ-008 SHALL have port sample_right, output, 16 bits: last accepted right sample, two's complement.
REQ-009 SHALL have port sample_valid, output, 1 bit: pair available.
REQ-010 SHALL have port sample_ready, input, 1 bit: consumer accepts the pair.
REQ-011 SHALL have port overrun, output, 1 bit: sticky, a completed pair was dropped.
REQ-012 SHALL have port frame_err, output, 1 bit: sticky, a word was truncated by an early LRCK edge.

Function
REQ-013 SHALL pass AUD_BCLK, AUD_ADCLRCK and AUD_ADCDAT through 2-flop synchronizers; the bit strobe is a 1-Clk pulse on a synchronized BCLK rising edge.
REQ-014 SHALL use the FSM states IDLE, SKIP, SHIFT and HOLD.
REQ-015 IDLE: waits for a synchronized LRCK edge (either polarity) on a bit strobe with enable=1, latches the channel from the LRCK level, then goes to SKIP.
REQ-016 SKIP: discards exactly one bit strobe (I2S one-bit delay), then goes to SHIFT.
REQ-017 SHIFT: left-shifts AUD_ADCDAT into a 16-bit shift register on each bit strobe; after the 16th bit it stores the word to the channel's holding register and goes to HOLD.
REQ-018 HOLD: ignores bits beyond 16; an LRCK edge on a strobe latches the new channel and goes to SKIP.
REQ-019 An LRCK edge in SHIFT before the 16th bit SHALL discard the partial word, set frame_err, and go to SKIP for the new channel.
REQ-020 Completion of a right word preceded by a stored left word in the same frame SHALL form a pair; a right word without a preceding left word SHALL be discarded silently.
REQ-021 A pair SHALL load sample_left/sample_right and assert sample_valid in the Clk cycle after the strobe of the 16th right bit, giving a pin-to-valid latency of 4 Clk cycles.
REQ-022 sample_valid SHALL stay high and the outputs SHALL stay stable until a cycle with sample_valid && sample_ready, after which sample_valid deasserts the next cycle.
REQ-023 A new pair arriving while sample_valid=1 and sample_ready=0 SHALL be dropped and SHALL set overrun; the outputs are unchanged.
REQ-024 A new pair arriving in the same cycle as a handshake SHALL be loaded with sample_valid kept high and SHALL NOT set overrun.
REQ-025 enable=0 SHALL return the FSM to IDLE at the next strobe; a pending pair and the sticky flags SHALL be retained.

Reset
REQ-026 Reset SHALL force IDLE and set sample_left=0, sample_right=0, sample_valid=0, overrun=0, frame_err=0, and clear the shift register, bit counter and synchronizers on the next Clk edge.
REQ-027 Reset mid-word or with a pending pair SHALL discard all data; no pair is presented until a full new frame completes.

Configuration
REQ-028 With AUDIO_RX_MONO_MIX_EN defined, sample_left and sample_right SHALL both carry (L+R)>>>1, computed 17 bits wide with an arithmetic shift; the added latency SHALL be 0 cycles.
REQ-029 Without AUDIO_RX_MONO_MIX_EN, the raw L and R samples SHALL be output.

Structure
REQ-030 The shared package audio_pkg SHALL hold the state enum rx_state_t, SAMPLE_W=16 and SYNC_STAGES=2.
REQ-031 A single sub-module, i2s_edge_sync, SHALL contain the synchronizers and the BCLK rising-edge strobe.

Verification
REQ-032 Send L=0xA5C3 and R=0x5A3C with sample_ready=1 -> sample_left=0xA5C3 and sample_right=0x5A3C, with sample_valid high for 1 cycle, 4 Clk after the last R bit.
REQ-033 Send two frames with sample_ready=0 -> the first pair is held, overrun=1, and the outputs still show the first pair.
REQ-034 Raise LRCK after 10 bits of a left word -> frame_err=1 and no pair is formed; the next complete frame is delivered correctly.
REQ-035 Assert Reset in the middle of SHIFT -> all outputs are 0 the next cycle; the next full frame 0x7FFF/0x8000 is delivered.
REQ-036 With AUDIO_RX_MONO_MIX_EN, send L=0x7FFF and R=0x0001 -> both outputs are 0x4000; send L=0x8000 and R=0x8000 -> both outputs are 0x8000.
REQ-037 Send 24-bit words (codec 24-bit mode) -> the upper 16 bits are captured and the extra bits are ignored in HOLD.
